// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, reservation entry type and latency clamp for the issue scoreboard
package regfile_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;
    localparam int LAT_W     = 3;
    localparam int ROW_W     = 4;   // wide enough for an effective latency of up to 8

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] idx;
    } resvEntry_t;

    function automatic logic [ROW_W-1:0] clampLat(input logic [LAT_W-1:0] lat, input int maxLat);
        if (lat == '0) return ROW_W'(1);
        if (int'(lat) > maxLat) return ROW_W'(maxLat);
        return ROW_W'(lat);
    endfunction

endpackage

// File: rtl/sb_resv_table.sv
// rtl/sb_resv_table.sv - write-port reservation table; row 0 is the write cycle in progress,
// rows shift down once per clock and new writes are appended at row L-1.
module sb_resv_table
    import regfile_pkg::*;
#(
    parameter int MAX_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ins1,
    input  logic [ROW_W-1:0]     row1,
    input  logic [REG_IDX_W-1:0] reg1,
    input  logic                 ins2,
    input  logic [ROW_W-1:0]     row2,
    input  logic [REG_IDX_W-1:0] reg2,
    output logic [NUM_REGS-1:0]  busyVec,
    output logic [NUM_REGS-1:0]  retVec,
    output logic                 retValid1,
    output logic [REG_IDX_W-1:0] retReg1,
    output logic                 retValid2,
    output logic [REG_IDX_W-1:0] retReg2,
    output logic [2*MAX_LAT-1:0] rowCnt
);

    resvEntry_t [1:0] tbl [MAX_LAT];
    resvEntry_t [1:0] nxt [MAX_LAT];

    // Entries already in a row are older than new ones, so appending keeps slot 0 the oldest.
    always_comb begin
        for (int j = 0; j < MAX_LAT; j++) nxt[j] = '0;
        for (int j = 0; j < MAX_LAT - 1; j++) nxt[j] = tbl[j + 1];
        for (int j = 0; j < MAX_LAT; j++) begin
            if (ins1 && row1 == ROW_W'(j)) begin
                if (!nxt[j][0].valid) nxt[j][0] = '{valid: 1'b1, idx: reg1};
                else                  nxt[j][1] = '{valid: 1'b1, idx: reg1};
            end
            if (ins2 && row2 == ROW_W'(j)) begin
                if (!nxt[j][0].valid) nxt[j][0] = '{valid: 1'b1, idx: reg2};
                else                  nxt[j][1] = '{valid: 1'b1, idx: reg2};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < MAX_LAT; j++) tbl[j] <= '0;
        end else begin
            for (int j = 0; j < MAX_LAT; j++) tbl[j] <= nxt[j];
        end
    end

    always_comb begin
        busyVec = '0;
        retVec  = '0;
        rowCnt  = '0;
        for (int j = 0; j < MAX_LAT; j++) begin
            for (int k = 0; k < 2; k++) begin
                if (tbl[j][k].valid) busyVec[tbl[j][k].idx] = 1'b1;
            end
            rowCnt[2*j +: 2] = 2'(tbl[j][0].valid) + 2'(tbl[j][1].valid);
        end
        for (int k = 0; k < 2; k++) begin
            if (tbl[0][k].valid) retVec[tbl[0][k].idx] = 1'b1;
        end
    end

    assign retValid1 = tbl[0][0].valid;
    assign retReg1   = tbl[0][0].valid ? tbl[0][0].idx : '0;
    assign retValid2 = tbl[0][1].valid;
    assign retReg2   = tbl[0][1].valid ? tbl[0][1].idx : '0;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - dual-issue register scoreboard with write-port reservation;
// define SB_FORWARD_EN to let sources read a register in its write cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int MAX_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issueValid1,
    input  logic [REG_IDX_W-1:0] rm1,
    input  logic [REG_IDX_W-1:0] rd1,
    input  logic                 wen1,
    input  logic [REG_IDX_W-1:0] dst1,
    input  logic [LAT_W-1:0]     lat1,
    input  logic                 issueValid2,
    input  logic [REG_IDX_W-1:0] rm2,
    input  logic [REG_IDX_W-1:0] rn2,
    input  logic [REG_IDX_W-1:0] rd2,
    input  logic                 wen2,
    input  logic [REG_IDX_W-1:0] dst2,
    input  logic [LAT_W-1:0]     lat2,
    output logic                 issueGrant1,
    output logic                 issueGrant2,
    output logic                 regWrite1,
    output logic                 regWrite2,
    output logic [REG_IDX_W-1:0] destReg1,
    output logic [REG_IDX_W-1:0] destReg2,
    output logic [NUM_REGS-1:0]  busyVec,
    output logic                 stall
);

    logic [ROW_W-1:0]     eLat1, eLat2;
    logic [NUM_REGS-1:0]  retVec, srcBusy;
    logic [2*MAX_LAT-1:0] rowCnt;
    logic [1:0]           pend1, pend2;
    logic [2:0]           cap2;
    logic                 write1, write2;

    assign eLat1 = clampLat(lat1, MAX_LAT);
    assign eLat2 = clampLat(lat2, MAX_LAT);

`ifdef SB_FORWARD_EN
    assign srcBusy = busyVec & ~retVec;
`else
    assign srcBusy = busyVec;
`endif

    // Writes landing L cycles ahead currently sit in row L; row MAX_LAT is always empty.
    always_comb begin
        pend1 = '0;
        pend2 = '0;
        for (int j = 1; j < MAX_LAT; j++) begin
            if (eLat1 == ROW_W'(j)) pend1 = rowCnt[2*j +: 2];
            if (eLat2 == ROW_W'(j)) pend2 = rowCnt[2*j +: 2];
        end
    end

    always_comb begin
        issueGrant1 = issueValid1 & ~srcBusy[rm1] & ~srcBusy[rd1]
                    & (~wen1 | (~busyVec[dst1] & (pend1 < 2'd2)));
        write1      = issueGrant1 & wen1;
        cap2        = {1'b0, pend2} + {2'b00, write1 & (eLat1 == eLat2)};
        issueGrant2 = issueValid2 & (~issueValid1 | issueGrant1)
                    & ~srcBusy[rm2] & ~srcBusy[rn2] & ~srcBusy[rd2]
                    & ~(write1 & ((rm2 == dst1) | (rn2 == dst1) | (rd2 == dst1)))
                    & (~wen2 | (~busyVec[dst2] & ~(write1 & (dst2 == dst1)) & (cap2 < 3'd2)));
        write2      = issueGrant2 & wen2;
    end

    assign stall = issueValid1 & ~issueGrant1;

    sb_resv_table #(.MAX_LAT(MAX_LAT)) uTable (
        .clk       (clk),
        .reset     (reset),
        .ins1      (write1),
        .row1      (eLat1 - ROW_W'(1)),
        .reg1      (dst1),
        .ins2      (write2),
        .row2      (eLat2 - ROW_W'(1)),
        .reg2      (dst2),
        .busyVec   (busyVec),
        .retVec    (retVec),
        .retValid1 (regWrite1),
        .retReg1   (destReg1),
        .retValid2 (regWrite2),
        .retReg2   (destReg2),
        .rowCnt    (rowCnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and random checks of regfile_scoreboard against a pending-write list model
module tb_regfile_scoreboard;

    localparam int ML = 4;
`ifdef SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       issueValid1, wen1, issueValid2, wen2;
    logic [2:0] rm1, rd1, dst1, lat1, rm2, rn2, rd2, dst2, lat2;
    logic       issueGrant1, issueGrant2, regWrite1, regWrite2, stall;
    logic [2:0] destReg1, destReg2;
    logic [7:0] busyVec;

    always #5 clk = ~clk;

    regfile_scoreboard #(.MAX_LAT(ML)) dut (
        .clk(clk), .reset(reset),
        .issueValid1(issueValid1), .rm1(rm1), .rd1(rd1), .wen1(wen1), .dst1(dst1), .lat1(lat1),
        .issueValid2(issueValid2), .rm2(rm2), .rn2(rn2), .rd2(rd2), .wen2(wen2), .dst2(dst2), .lat2(lat2),
        .issueGrant1(issueGrant1), .issueGrant2(issueGrant2),
        .regWrite1(regWrite1), .regWrite2(regWrite2),
        .destReg1(destReg1), .destReg2(destReg2),
        .busyVec(busyVec), .stall(stall)
    );

    // Pending writes as (absolute write cycle, register), kept in issue order.
    int pCyc[$];
    int pReg[$];
    int now = 0;
    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nChecks++;
        if (obs !== want) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, want, now);
        end
    endtask

    function automatic int effLat(input logic [2:0] l);
        if (l == 3'd0) return 1;
        if (int'(l) > ML) return ML;
        return int'(l);
    endfunction

    function automatic bit pending(input int r);
        foreach (pReg[i]) if (pReg[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit retiring(input int r);
        foreach (pReg[i]) if (pReg[i] == r && pCyc[i] == now) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int portsUsed(input int c);
        int n = 0;
        foreach (pCyc[i]) if (pCyc[i] == c) n++;
        return n;
    endfunction

    function automatic bit srcHeld(input int r);
        return pending(r) && !(FWD && retiring(r));
    endfunction

    task automatic setSlot1(input int v, input int rm, input int rd, input int w, input int dst, input int lat);
        issueValid1 = (v != 0); rm1 = 3'(rm); rd1 = 3'(rd);
        wen1 = (w != 0); dst1 = 3'(dst); lat1 = 3'(lat);
    endtask

    task automatic setSlot2(input int v, input int rm, input int rn, input int rd,
                            input int w, input int dst, input int lat);
        issueValid2 = (v != 0); rm2 = 3'(rm); rn2 = 3'(rn); rd2 = 3'(rd);
        wen2 = (w != 0); dst2 = 3'(dst); lat2 = 3'(lat);
    endtask

    task automatic idle();
        setSlot1(0, 0, 0, 0, 0, 0);
        setSlot2(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check the current cycle against the model, advance the model, then wait for the next drive point.
    task automatic tick();
        bit g1, g2, w1, w2;
        int l1, l2;
        int rv[$];
        logic [7:0] bv;
        #1;
        l1 = effLat(lat1);
        l2 = effLat(lat2);
        g1 = issueValid1 && !srcHeld(rm1) && !srcHeld(rd1)
             && (!wen1 || (!pending(dst1) && portsUsed(now + l1) < 2));
        w1 = g1 && wen1;
        g2 = issueValid2 && (!issueValid1 || g1)
             && !srcHeld(rm2) && !srcHeld(rn2) && !srcHeld(rd2)
             && !(w1 && (rm2 == dst1 || rn2 == dst1 || rd2 == dst1))
             && (!wen2 || (!pending(dst2) && !(w1 && dst2 == dst1)
                           && portsUsed(now + l2) + int'(w1 && l1 == l2) < 2));
        w2 = g2 && wen2;
        bv = '0;
        foreach (pReg[i]) bv[pReg[i]] = 1'b1;
        foreach (pCyc[i]) if (pCyc[i] == now) rv.push_back(pReg[i]);
        check("grant1", issueGrant1, g1);
        check("grant2", issueGrant2, g2);
        check("stall", stall, issueValid1 && !g1);
        check("busyVec", busyVec, bv);
        check("regWrite1", regWrite1, rv.size() > 0);
        check("destReg1", destReg1, rv.size() > 0 ? rv[0] : 0);
        check("regWrite2", regWrite2, rv.size() > 1);
        check("destReg2", destReg2, rv.size() > 1 ? rv[1] : 0);
        for (int i = pCyc.size() - 1; i >= 0; i--) begin
            if (pCyc[i] == now) begin
                pCyc.delete(i);
                pReg.delete(i);
            end
        end
        if (w1) begin pCyc.push_back(now + l1); pReg.push_back(dst1); end
        if (w2) begin pCyc.push_back(now + l2); pReg.push_back(dst2); end
        now++;
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        repeat (ML + 2) tick();
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #1;
        check("rst_busy", busyVec, 0);
        check("rst_wr1", regWrite1, 0);
        check("rst_wr2", regWrite2, 0);
        check("rst_dst1", destReg1, 0);
        check("rst_dst2", destReg2, 0);
        pCyc.delete();
        pReg.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        check("init_busy", busyVec, 0);
        check("init_wr1", regWrite1, 0);
        check("init_wr2", regWrite2, 0);
        reset = 1'b1;

        // Single write, lat 2
        setSlot1(1, 0, 0, 1, 3, 2);
        #1 check("r27_grant", issueGrant1, 1);
        tick();
        idle();
        #1 check("r27_busy1", busyVec, 8'h08);
        check("r27_nowr", regWrite1, 0);
        tick();
        #1 check("r27_busy2", busyVec, 8'h08);
        check("r27_wr", regWrite1, 1);
        check("r27_dst", destReg1, 3);
        tick();
        #1 check("r27_clear", busyVec, 0);
        check("r27_wrdone", regWrite1, 0);
        tick();
        drain();

        // RAW stall on r3
        setSlot1(1, 0, 0, 1, 3, 2);
        tick();
        setSlot1(1, 3, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 check("r28_stall", stall, (k == 0) || (k == 1 && !FWD));
            tick();
        end
        drain();

        // Slot 2 reads slot 1's destination
        setSlot1(1, 0, 0, 1, 2, 1);
        setSlot2(1, 2, 0, 0, 0, 0, 0);
        #1 check("r29_g1", issueGrant1, 1);
        check("r29_g2", issueGrant2, 0);
        tick();
        setSlot1(0, 0, 0, 0, 0, 0);
        #1 check("r29_retry", issueGrant2, FWD);
        tick();
        #1 check("r29_after", issueGrant2, 1);
        tick();
        drain();

        // Write-port saturation
        setSlot1(1, 0, 0, 1, 4, 3);
        setSlot2(1, 0, 0, 0, 1, 5, 3);
        #1 check("r30_pair", issueGrant2, 1);
        tick();
        setSlot2(0, 0, 0, 0, 0, 0, 0);
        setSlot1(1, 0, 0, 1, 6, 2);
        #1 check("r30_full", issueGrant1, 0);
        lat1 = 3'd3;
        #1 check("r30_free", issueGrant1, 1);
        tick();
        drain();

        // Dual retire
        setSlot1(1, 0, 0, 1, 1, 1);
        setSlot2(1, 0, 0, 0, 1, 5, 1);
        tick();
        idle();
        #1 check("r31_wr1", regWrite1, 1);
        check("r31_dst1", destReg1, 1);
        check("r31_wr2", regWrite2, 1);
        check("r31_dst2", destReg2, 5);
        tick();
        drain();

        // Reset with three writes pending
        setSlot1(1, 0, 0, 1, 1, 4);
        setSlot2(1, 0, 0, 0, 1, 2, 4);
        tick();
        setSlot2(0, 0, 0, 0, 0, 0, 0);
        setSlot1(1, 0, 0, 1, 3, 4);
        tick();
        idle();
        #1 check("r32_pending", busyVec, 8'h0E);
        pulseReset();
        drain();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) pulseReset();
            setSlot1(int'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
            setSlot2(int'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 7));
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
